bcd_seg_scanner: RTL and testbench

// - Display-side consumer for the BCD counters. Takes NUM_DIGITS packed BCD digits and

---
 rtl/bcd_seg_scanner.sv | 184 ++++++++++++++++++
 tb/tb_bcd_seg_scanner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 7-segment scanner for packed BCD digits.
// A free-running divider advances the active digit; the staging register captures
// new data at any time, and the shadow register that feeds the decoder only updates
// at a frame boundary, so a display frame always comes from one consistent load.
module bcd_seg_scanner #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter bit          BLANK_LEAD = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done,
   output logic                    err
);

   localparam int unsigned IdxWidth = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NUM_DIGITS - 1);

   // Inactive output levels depend on the display polarity.
   localparam logic [6:0]            SegOff = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DpOff  = ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AnOff  = ACTIVE_LOW ? '1 : '0;

   // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] val);
      logic [6:0] pat;
      case (val)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h40;
      endcase
      return pat;
   endfunction

   // State
   logic [DIV_WIDTH-1:0]    div_q, div_d;
   logic [IdxWidth-1:0]     idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] stage_bcd_q, stage_bcd_d;
   logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
   logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic                    frame_done_q, frame_done_d;
   logic                    err_q, err_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   // Combinational helpers
   logic                    tick;
   logic                    boundary;
   logic                    stage_bad;
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic                    zero_acc;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   cur_an;
   logic [6:0]              seg_raw;

   assign tick     = (div_q == '1);
   assign boundary = tick && (idx_q == LastIdx);

   // Any staged nibble outside 0..9 marks the load as invalid.
   always_comb begin
      stage_bad = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (stage_bcd_q[4*i +: 4] > 4'd9) begin
            stage_bad = 1'b1;
         end
      end
   end

   // lead_zero[i]: shadow nibbles i..top are all zero (scanned from the top down).
   always_comb begin
      lead_zero = '0;
      zero_acc  = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         zero_acc     = zero_acc & (shadow_bcd_q[4*i +: 4] == 4'd0);
         lead_zero[i] = zero_acc;
      end
   end

   // Select the nibble, dp bit, blank flag and anode for the current digit.
   always_comb begin
      cur_nib   = 4'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_an    = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IdxWidth'(i)) begin
            cur_nib   = shadow_bcd_q[4*i +: 4];
            cur_dp    = shadow_dp_q[i];
            cur_blank = BLANK_LEAD && (i != 0) && lead_zero[i];
            cur_an[i] = 1'b1;
         end
      end
   end

   // Next-state logic for the divider, digit index, data registers and outputs.
   always_comb begin
      div_d        = div_q + DIV_WIDTH'(1);
      idx_d        = idx_q;
      stage_bcd_d  = stage_bcd_q;
      stage_dp_d   = stage_dp_q;
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
      frame_done_d = 1'b0;
      err_d        = err_q;

      if (tick) begin
         idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxWidth'(1);
      end

      // Shadow takes the staging value as it stood before this edge, so a load in
      // the same cycle only becomes visible one frame later.
      if (boundary) begin
         shadow_bcd_d = stage_bcd_q;
         shadow_dp_d  = stage_dp_q;
         frame_done_d = 1'b1;
         err_d        = err_q | stage_bad;
      end

      if (load) begin
         stage_bcd_d = bcd_in;
         stage_dp_d  = dp_in;
      end

      seg_raw = cur_blank ? 7'h00 : seg_decode(cur_nib);
      seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
      dp_d    = ACTIVE_LOW ? ~cur_dp : cur_dp;
      an_d    = ACTIVE_LOW ? ~cur_an : cur_an;
   end

   // State register with synchronous reset; outputs go inactive while in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q        <= '0;
         idx_q        <= '0;
         stage_bcd_q  <= '0;
         stage_dp_q   <= '0;
         shadow_bcd_q <= '0;
         shadow_dp_q  <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         seg_q        <= SegOff;
         dp_q         <= DpOff;
         an_q         <= AnOff;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         stage_bcd_q  <= stage_bcd_d;
         stage_dp_q   <= stage_dp_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_dp_q  <= shadow_dp_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign an_out     = an_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner: 4 digits, divide-by-4 refresh, active-low
// outputs, leading-zero blanking.
module tb_bcd_seg_scanner;

   logic        clk;
   logic        rst;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        load;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  an_out;
   logic        frame_done;
   logic        err;

   int checks = 0;
   int errors = 0;

   bcd_seg_scanner #(
      .NUM_DIGITS(4),
      .DIV_WIDTH (2),
      .ACTIVE_LOW(1'b1),
      .BLANK_LEAD(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bcd_in    (bcd_in),
      .dp_in     (dp_in),
      .load      (load),
      .seg_out   (seg_out),
      .dp_out    (dp_out),
      .an_out    (an_out),
      .frame_done(frame_done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One load plus the expected scan of the following frame (active-low levels).
   typedef struct packed {
      logic [15:0]     bcd;
      logic [3:0]      dp;
      logic [3:0][6:0] seg;
      logic [3:0]      dpo;
      logic            err;
   } vec_t;

   vec_t       vecs [6];
   logic [3:0] an_exp [4];

   function automatic vec_t mk(input logic [15:0] b, input logic [3:0] d,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] o, input logic e);
      vec_t v;
      v.bcd = b;
      v.dp  = d;
      v.seg = {s3, s2, s1, s0};
      v.dpo = o;
      v.err = e;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] b, input logic [3:0] d);
      bcd_in = b;
      dp_in  = d;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   // Steps until frame_done is seen, bounded; leaves time just after the boundary edge.
   task automatic wait_frame_done();
      bit found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         step();
         if (frame_done === 1'b1) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL frame_done_timeout: got 0, expected 1 within 64 cycles");
      end
   endtask

   initial begin
      an_exp[0] = 4'hE;
      an_exp[1] = 4'hD;
      an_exp[2] = 4'hB;
      an_exp[3] = 4'h7;

      //            bcd       dp       d0     d1     d2     d3     dp_out   err
      vecs[0] = mk(16'h1234, 4'b0000, 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, 1'b0);
      vecs[1] = mk(16'h9876, 4'b1000, 7'h02, 7'h78, 7'h00, 7'h10, 4'b0111, 1'b0);
      vecs[2] = mk(16'h0007, 4'b0000, 7'h78, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 1'b0);
      vecs[3] = mk(16'h00A5, 4'b0000, 7'h12, 7'h3F, 7'h7F, 7'h7F, 4'b1111, 1'b1);
      vecs[4] = mk(16'h0000, 4'b0000, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 1'b1);
      vecs[5] = mk(16'h0090, 4'b0110, 7'h40, 7'h10, 7'h7F, 7'h7F, 4'b1001, 1'b1);

      rst    = 1'b1;
      load   = 1'b0;
      bcd_in = '0;
      dp_in  = '0;

      // Reset: everything inactive
      steps(3);
      chk("rst_seg", 32'(seg_out), 32'h7F);
      chk("rst_an", 32'(an_out), 32'hF);
      chk("rst_dp", 32'(dp_out), 32'h1);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);

      // Release: digit 0 shows "0"
      rst = 1'b0;
      step();
      chk("rel_an", 32'(an_out), 32'hE);
      chk("rel_seg", 32'(seg_out), 32'h40);
      chk("rel_dp", 32'(dp_out), 32'h1);

      // A load does not reach the display before the frame boundary
      do_load(16'h1234, 4'b0000);
      step();
      chk("preframe_seg", 32'(seg_out), 32'h40);
      chk("preframe_an", 32'(an_out), 32'hE);

      // Table: load, wait for boundary, check each digit of the next frame
      for (int v = 0; v < 6; v++) begin
         do_load(vecs[v].bcd, vecs[v].dp);
         wait_frame_done();
         for (int d = 0; d < 4; d++) begin
            step();
            if (d == 0) chk($sformatf("v%0d_fd_pulse", v), 32'(frame_done), 32'h0);
            chk($sformatf("v%0d_d%0d_seg", v, d), 32'(seg_out), 32'(vecs[v].seg[d]));
            chk($sformatf("v%0d_d%0d_an", v, d), 32'(an_out), 32'(an_exp[d]));
            chk($sformatf("v%0d_d%0d_dp", v, d), 32'(dp_out), 32'(vecs[v].dpo[d]));
            chk($sformatf("v%0d_d%0d_err", v, d), 32'(err), 32'(vecs[v].err));
            steps(3);
         end
      end

      // Load coincident with the boundary: old staging shows first, new one a frame later
      do_load(16'h0042, 4'b0000);
      steps(14);
      bcd_in = 16'h0051;
      dp_in  = 4'b0000;
      load   = 1'b1;
      step();
      load   = 1'b0;
      chk("coinc_fd", 32'(frame_done), 32'h1);
      step();
      chk("coinc_old_d0_seg", 32'(seg_out), 32'h24);
      chk("coinc_old_d0_an", 32'(an_out), 32'hE);
      steps(4);
      chk("coinc_old_d1_seg", 32'(seg_out), 32'h19);
      chk("coinc_old_d1_an", 32'(an_out), 32'hD);
      wait_frame_done();
      step();
      chk("coinc_new_d0_seg", 32'(seg_out), 32'h79);
      chk("coinc_new_d0_an", 32'(an_out), 32'hE);
      steps(4);
      chk("coinc_new_d1_seg", 32'(seg_out), 32'h12);
      steps(4);
      chk("coinc_new_d2_seg", 32'(seg_out), 32'h7F);
      chk("coinc_new_d2_an", 32'(an_out), 32'hB);

      // Mid-frame reset with idx == 2
      rst = 1'b1;
      step();
      chk("midrst_seg", 32'(seg_out), 32'h7F);
      chk("midrst_an", 32'(an_out), 32'hF);
      chk("midrst_dp", 32'(dp_out), 32'h1);
      chk("midrst_err", 32'(err), 32'h0);
      rst = 1'b0;
      step();
      chk("midrst_rel_seg", 32'(seg_out), 32'h40);
      chk("midrst_rel_an", 32'(an_out), 32'hE);
      steps(3);
      chk("midrst_d0_last_an", 32'(an_out), 32'hE);
      step();
      chk("midrst_d1_an", 32'(an_out), 32'hD);
      chk("midrst_d1_seg", 32'(seg_out), 32'h7F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
